seq_det_ctrl: RTL and testbench

Controller and sequencer for a programmable Mealy overlapping serial sequence detector.
- Accepts a pattern, length and match threshold over a valid/ready config handshake.
- Arms and disarms the detector and counts matches.
- Signals completion when the threshold is reached.
- Sits between the register/config side and the serial bit stream that feeds the detector datapath.

---
 rtl/seq_det_pkg.sv | 28 ++
 rtl/seq_det_core.sv | 76 +++++++
 rtl/seq_det_ctrl.sv | 152 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and helpers for the serial sequence detector
// Contents:
//   state_e   : controller state (IDLE / ARMED / DONE)
//   DEF_PAT_W : default maximum pattern length
//   DEF_CNT_W : default match counter / threshold width
//   len_mask  : pattern length -> mask with the low 'len' bits set
package seq_det_pkg;

   localparam int DEF_PAT_W = 4;
   localparam int DEF_CNT_W = 8;
   localparam int MAX_PAT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Callers truncate the result to their own pattern width.
   function automatic logic [MAX_PAT_W-1:0] len_mask(input int len);
      logic [MAX_PAT_W-1:0] m;
      for (int i = 0; i < MAX_PAT_W; i++) begin
         m[i] = (i < len);
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - history shift register, fill counter and masked compare producing the Mealy match
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   clr_i          : clear history and fill (arming)
//   en_i           : detector active this cycle (armed and not aborting)
//   x_valid_i, x_i : qualified serial bit
//   pattern_i      : pattern, bit [len-1] oldest, bit [0] newest
//   len_i          : effective pattern length, already clamped to 1..PAT_W
//   ovl_i          : 1 = overlapping detection, 0 = restart after each match
//   z_o            : combinational match, same cycle as the final bit
module seq_det_core
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   localparam int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             x_valid_i,
   input  logic             x_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             ovl_i,
   output logic             z_o
);

   localparam int HIST_W = (PAT_W > 1) ? PAT_W - 1 : 1;

   logic [HIST_W-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]  fill_q, fill_d;
   logic [PAT_W-1:0]  mask;
   logic [PAT_W-1:0]  window;
   logic              enough_bits;
   logic              hit;

   assign mask   = PAT_W'(len_mask(int'(len_i)));
   // Current bit joins the stored history so the match is visible in the same cycle.
   assign window = PAT_W'({hist_q, x_i});

   // fill counts bits already stored; the current bit makes fill+1 available.
   assign enough_bits = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_i};
   assign hit         = ((window ^ pattern_i) & mask) == '0;
   assign z_o         = en_i & x_valid_i & enough_bits & hit;

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (clr_i) begin
         hist_d = '0;
         fill_d = '0;
      end else if (en_i && x_valid_i) begin
         if (z_o && !ovl_i) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = HIST_W'({hist_q, x_i});
            if (fill_q != LEN_W'(PAT_W)) begin
               fill_d = fill_q + LEN_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - config, arming FSM and match counter for the programmable sequence detector
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   cfg_valid / cfg_ready         : config handshake, ready only in IDLE
//   cfg_pattern, cfg_len          : pattern and length (0 -> 1, >PAT_W -> PAT_W)
//   cfg_thresh                    : matches required for done, 0 = free-run
//   cfg_ovl                       : overlap enable, present only with SEQ_DET_NONOVL_EN
//   start / abort                 : arm / disarm pulses
//   x_valid, x                    : serial bit stream
//   z                             : Mealy match (combinational)
//   match_cnt, busy, done         : saturating match count and status
// Build option: SEQ_DET_NONOVL_EN adds cfg_ovl for non-overlapping detection.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W,
   localparam int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_thresh,
`ifdef SEQ_DET_NONOVL_EN
   input  logic             cfg_ovl,
`endif
   input  logic             start,
   input  logic             abort,
   input  logic             x_valid,
   input  logic             x,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   logic [PAT_W-1:0] pattern_q;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] thresh_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, done_q, ready_q;
   logic             core_en, core_clr, core_ovl;

`ifdef SEQ_DET_NONOVL_EN
   logic ovl_q;
   assign core_ovl = ovl_q;
`else
   assign core_ovl = 1'b1;
`endif

   // Length is clamped once at latch so the datapath only ever sees 1..PAT_W.
   assign len_d = (cfg_len == '0)              ? LEN_W'(1)     :
                  (cfg_len > LEN_W'(PAT_W))    ? LEN_W'(PAT_W) : cfg_len;
   assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

   // abort suppresses the match in the same cycle; in IDLE abort is a no-op so start still arms.
   assign core_en  = (state_q == ST_ARMED) & ~abort;
   assign core_clr = start & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & ~abort));

   seq_det_core #(
      .PAT_W (PAT_W)
   ) u_core (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (core_clr),
      .en_i      (core_en),
      .x_valid_i (x_valid),
      .x_i       (x),
      .pattern_i (pattern_q),
      .len_i     (len_q),
      .ovl_i     (core_ovl),
      .z_o       (z)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pattern_q <= '0;
         len_q     <= LEN_W'(1);
         thresh_q  <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
`ifdef SEQ_DET_NONOVL_EN
         ovl_q     <= 1'b1;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cfg_valid) begin
                  pattern_q <= cfg_pattern;
                  len_q     <= len_d;
                  thresh_q  <= cfg_thresh;
`ifdef SEQ_DET_NONOVL_EN
                  ovl_q     <= cfg_ovl;
`endif
               end
               if (start) begin
                  state_q <= ST_ARMED;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else if (z) begin
                  cnt_q <= cnt_d;
                  if ((thresh_q != '0) && (cnt_d == thresh_q)) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else if (start) begin
                  state_q <= ST_ARMED;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cfg_ready = ready_q;
   assign match_cnt = cnt_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - self-checking bench for seq_det_ctrl (table vectors, corner sequences, random vs model)
module tb_seq_det_ctrl;

   localparam int PAT_W = 4;
   localparam int CNT_W = 8;
   localparam int LEN_W = 3;

   logic             clk, rst, cfg_valid, cfg_ready, start, abort, x_valid, x, z, busy, done;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic [CNT_W-1:0] cfg_thresh, match_cnt;
`ifdef SEQ_DET_NONOVL_EN
   logic             cfg_ovl;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: state as a small integer, received bits kept in a queue.
   int m_st;   // 0 idle, 1 armed, 2 done
   int m_pat, m_len, m_thr, m_cnt;
   bit m_ovl;
   bit m_q[$];

   bit zs;
   bit bits7 [7] = '{1, 0, 1, 1, 0, 1, 1};
   bit exp_gap [7] = '{0, 0, 0, 1, 0, 0, 0};
   bit bits5 [5] = '{1, 0, 1, 1, 0};
   bit exp_len0 [5] = '{1, 0, 1, 1, 0};
   bit exp_4 [4] = '{0, 0, 0, 1};

   typedef struct {
      bit cv; int pat; int ln; int th; bit st; bit ab; bit xv; bit xb;
      bit ez; int ecnt; bit ebusy; bit edone;
   } vec_t;
   vec_t tbl[$];

   seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_thresh  (cfg_thresh),
`ifdef SEQ_DET_NONOVL_EN
      .cfg_ovl     (cfg_ovl),
`endif
      .start       (start),
      .abort       (abort),
      .x_valid     (x_valid),
      .x           (x),
      .z           (z),
      .match_cnt   (match_cnt),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_pat = 0; m_len = 1; m_thr = 0; m_cnt = 0; m_ovl = 1'b1;
      m_q.delete();
   endtask

   function automatic bit model_z(input bit ab, input bit xv, input bit xb);
      bit t[$];
      if (m_st != 1 || ab || !xv) return 1'b0;
      t = m_q;
      t.push_back(xb);
      if (t.size() < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++) begin
         if (t[t.size() - 1 - i] != m_pat[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_edge(input bit cv, input int pat, input int ln, input int th, input bit ovl,
                             input bit st, input bit ab, input bit xv, input bit xb, input bit zz);
      case (m_st)
         0: begin
            if (cv) begin
               m_pat = pat;
               m_len = (ln == 0) ? 1 : ((ln > PAT_W) ? PAT_W : ln);
               m_thr = th;
               m_ovl = ovl;
            end
            if (st) begin m_st = 1; m_cnt = 0; m_q.delete(); end
         end
         1: begin
            if (ab) m_st = 0;
            else if (xv) begin
               m_q.push_back(xb);
               if (m_q.size() > PAT_W) void'(m_q.pop_front());
               if (zz) begin
                  if (m_cnt < 255) m_cnt++;
                  if (!m_ovl) m_q.delete();
                  if (m_thr != 0 && m_cnt == m_thr) m_st = 2;
               end
            end
         end
         default: begin
            if (ab) m_st = 0;
            else if (st) begin m_st = 1; m_cnt = 0; m_q.delete(); end
         end
      endcase
   endtask

   // Entered just after a falling edge; leaves just after the next falling edge.
   task automatic step(input bit cv, input int pat, input int ln, input int th, input bit ovl,
                       input bit st, input bit ab, input bit xv, input bit xb, output bit zo);
      bit ez;
      cfg_valid   = cv;
      cfg_pattern = pat[PAT_W-1:0];
      cfg_len     = ln[LEN_W-1:0];
      cfg_thresh  = th[CNT_W-1:0];
`ifdef SEQ_DET_NONOVL_EN
      cfg_ovl     = ovl;
`endif
      start = st; abort = ab; x_valid = xv; x = xb;
      #1;
      ez = model_z(ab, xv, xb);
      zo = z;
      chk("z", int'(z), int'(ez));
      model_edge(cv, pat, ln, th, ovl, st, ab, xv, xb, ez);
      @(negedge clk);
      chk("cfg_ready", int'(cfg_ready), int'(m_st == 0));
      chk("busy", int'(busy), int'(m_st == 1));
      chk("done", int'(done), int'(m_st == 2));
      chk("match_cnt", int'(match_cnt), m_cnt);
   endtask

   task automatic idle_step();
      bit d;
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, d);
   endtask

   initial begin
      bit ovl_r;
      rst = 1'b1; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
      start = 0; abort = 0; x_valid = 0; x = 0;
`ifdef SEQ_DET_NONOVL_EN
      cfg_ovl = 1'b1;
`endif
      model_reset();
      #3;
      chk("rst_ready", int'(cfg_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_cnt", int'(match_cnt), 0);
      chk("rst_z", int'(z), 0);
      @(negedge clk);
      rst = 1'b0;

      // Overlapping detection, then threshold/done, as constant-expectation vectors.
      tbl.push_back('{1, 4'b1011, 4, 0, 1, 0, 0, 0,  0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  1, 1, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  1, 2, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0,  0, 2, 0, 0});
      tbl.push_back('{1, 4'b0011, 2, 3, 1, 0, 0, 0,  0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  1, 1, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  1, 2, 1, 0});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  1, 3, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  0, 3, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0,  0, 3, 0, 0});
      foreach (tbl[i]) begin
         step(tbl[i].cv, tbl[i].pat, tbl[i].ln, tbl[i].th, 1, tbl[i].st, tbl[i].ab,
              tbl[i].xv, tbl[i].xb, zs);
         chk("tbl_z", int'(zs), int'(tbl[i].ez));
         chk("tbl_cnt", int'(match_cnt), tbl[i].ecnt);
         chk("tbl_busy", int'(busy), int'(tbl[i].ebusy));
         chk("tbl_done", int'(done), int'(tbl[i].edone));
      end

      // Gaps between bits give the same z pattern; abort on the final bit kills its match.
      step(1, 4'b1011, 4, 0, 1, 1, 0, 0, 0, zs);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) step(0, 0, 0, 0, 1, 0, 0, 0, 1, zs);
         step(0, 0, 0, 0, 1, 0, (i == 6), 1, bits7[i], zs);
         chk("gap_z", int'(zs), int'(exp_gap[i]));
      end
      chk("abort_cnt", int'(match_cnt), 1);
      chk("abort_idle", int'(cfg_ready), 1);

      // Config offered while armed is not taken.
      step(1, 4'b1011, 4, 0, 1, 1, 0, 0, 0, zs);
      chk("armed_ready", int'(cfg_ready), 0);
      step(1, 4'b0000, 1, 0, 1, 0, 0, 0, 0, zs);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, 0, 0, 1, bits7[i], zs);
         chk("cfg_ign_z", int'(zs), int'(exp_4[i]));
      end
      step(0, 0, 0, 0, 1, 0, 1, 0, 0, zs);

      // Length 0 acts as a single-bit pattern.
      step(1, 4'b0001, 0, 0, 1, 1, 0, 0, 0, zs);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 1, 0, 0, 1, bits5[i], zs);
         chk("len0_z", int'(zs), int'(exp_len0[i]));
      end
      chk("len0_cnt", int'(match_cnt), 3);
      step(0, 0, 0, 0, 1, 0, 1, 0, 0, zs);

      // Length above PAT_W clamps to PAT_W.
      step(1, 4'b1011, 7, 0, 1, 1, 0, 0, 0, zs);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, 0, 0, 1, bits7[i], zs);
         chk("len7_z", int'(zs), int'(exp_4[i]));
      end

      // Asynchronous reset mid-stream while the next bit would complete a match.
      step(0, 0, 0, 0, 1, 0, 0, 1, 0, zs);
      step(0, 0, 0, 0, 1, 0, 0, 1, 1, zs);
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, zs);
      x_valid = 1; x = 1;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_z", int'(z), 0);
      chk("mid_rst_ready", int'(cfg_ready), 1);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_cnt", int'(match_cnt), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, 0, 1, 0, 0, 1, 1, zs);
      chk("post_rst_z", int'(zs), 0);
      // Reset config is pattern 0, length 1: a 0 bit matches once armed.
      step(0, 0, 0, 0, 1, 1, 0, 0, 0, zs);
      step(0, 0, 0, 0, 1, 0, 0, 1, 0, zs);
      chk("rst_cfg_z", int'(zs), 1);
      step(0, 0, 0, 0, 1, 0, 1, 0, 0, zs);

`ifdef SEQ_DET_NONOVL_EN
      step(1, 4'b1011, 4, 0, 0, 1, 0, 0, 0, zs);
      for (int i = 0; i < 7; i++) begin
         step(0, 0, 0, 0, 1, 0, 0, 1, bits7[i], zs);
         chk("nonovl_z", int'(zs), int'(exp_gap[i]));
      end
      chk("nonovl_cnt", int'(match_cnt), 1);
      step(0, 0, 0, 0, 1, 0, 1, 0, 0, zs);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 800; n++) begin
`ifdef SEQ_DET_NONOVL_EN
         ovl_r = 1'($urandom_range(0, 1));
`else
         ovl_r = 1'b1;
`endif
         step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 4)), ovl_r, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), zs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
